onchip_mem_dp_ctrl: RTL
=======================

# onchip_mem_dp_ctrl

Parametrised true-dual-port on-chip memory with two Avalon-MM slave ports (A, B) on one clock. It is the next-generation program/data memory for the NIOS/UART subsystem. Over the current fixed 32-bit x 17920 RAM it adds:
- configurable width, depth and read latency;
- a readdatavalid pipeline;
- a deterministic cross-port collision policy;
- a zero-fill clear engine with waitrequest back-pressure;
- out-of-range detection.

## Interface
Parameters:
- DATA_W, 32, data width; multiple of 8.
- ADDR_W, 15, word-address width.
- DEPTH, 17920, number of words; DEPTH <= 2**ADDR_W.
- READ_LATENCY, 1, cycles from read acceptance to readdatavalid; legal values 1 or 2.
- CLEAR_ON_RESET, 1, when 1, zero-fill runs automatically after reset.

Ports (x = a, b; one set per port):
- clk  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- x_address  in  ADDR_W  word address.
- x_byteenable  in  DATA_W/8  byte lanes for writes.
- x_chipselect  in  1  port select.
- x_read  in  1  read request.
- x_write  in  1  write request.
- x_writedata  in  DATA_W  write data.
- x_readdata  out  DATA_W  read data; qualified by x_readdatavalid.
- x_readdatavalid  out  1  one-cycle pulse per accepted read.
- x_waitrequest  out  1  high = request not accepted.
- clear_req  in  1  single-cycle pulse; starts zero-fill.
- init_busy  out  1  high while zero-fill runs.
- oob_err  out  1  sticky; set on any accepted access with address >= DEPTH.

## Operation
- State machine has two states, CLEAR and READY.
- Reset: state <= CLEAR if CLEAR_ON_RESET, else READY. clr_cnt <= 0. oob_err <= 0. Read pipelines flushed.
- CLEAR:
  - writes all-zero to word clr_cnt each cycle using all byte lanes;
  - clr_cnt increments each cycle;
  - at clr_cnt == DEPTH-1, the final write happens and state -> READY;
  - both waitrequests are high; no request is accepted;
  - reads already in the pipeline still complete.
- READY:
  - waitrequests are low;
  - clear_req -> CLEAR with clr_cnt <= 0; a request presented in that same cycle is accepted;
  - clear_req during CLEAR is ignored.
- Acceptance: x_chipselect & (x_read | x_write) & ~x_waitrequest.
- If read and write are both asserted on one port, the write is performed and the read is dropped (no readdatavalid).
- Writes: update only the enabled bytes. An address >= DEPTH drops the write and sets oob_err.
- Reads: an address >= DEPTH returns 0, still pulses readdatavalid, and sets oob_err.
- Collisions in the same cycle, same address:
  - write A + write B: A's enabled bytes win; B's bytes that A does not enable are applied.
  - write on one port + read on the other: the read returns the post-write (merged) word via forwarding.
  - read + read: both return the stored word.
- oob_err clears only on reset.

## Timing
- Reset values: x_readdata = 0, x_readdatavalid = 0, oob_err = 0. init_busy = x_waitrequest = CLEAR_ON_RESET.
- x_waitrequest and init_busy decode only the state register; no combinational path from inputs.
- Read latency is exactly READ_LATENCY cycles:
  - latency 1 = registered array output;
  - latency 2 = extra output register.
- Back-to-back reads every cycle are allowed; readdatavalid pulses in order, one per read.
- x_readdata holds its last value while readdatavalid is low.
- Auto-clear takes DEPTH cycles. The first request is accepted in cycle DEPTH+1 after reset deasserts.
- Reset asserted mid-clear restarts the clear from word 0.
- Reset asserted with reads in flight: the reads are discarded and no readdatavalid is issued.

## Structure
- Shared package onchip_mem_pkg holds:
  - state enum {CLEAR, READY};
  - function for the byte-merge of two writes;
  - localparam BE_W = DATA_W/8.
- Sub-module dpram_core: inferred true-dual-port array with per-port byteenable and one registered read per port, no reset on the array.
- Top level holds: FSM, clear counter muxed onto port A, collision/forwarding logic, optional latency-2 register stage, OOB compare.

## Test plan
Defaults unless stated: DATA_W=32, DEPTH=17920, READ_LATENCY=1, CLEAR_ON_RESET=1.
- Reset -> init_busy and waitrequest high for 17920 cycles. Then a read of 0x0000 and a read of 0x45FF each return 0x00000000 one cycle later with readdatavalid.
- A writes 0x11223344 to 0x0010, be=4'b1111. B then writes 0xAABBCCDD to 0x0010, be=4'b0101. A read of 0x0010 returns 0x11BB33DD.
- Same cycle, address 0x0020: A writes 0x000000FF with be=4'b0001, B writes 0x12345678 with be=4'b1111. A read returns 0x123456FF.
- Same cycle: A writes 0xDEADBEEF to 0x0030 while B reads 0x0030. B_readdata = 0xDEADBEEF after READ_LATENCY (check both 1 and 2).
- A reads 0x4600 (>= DEPTH) -> readdata 0, readdatavalid 1, oob_err 1. A following write to 0x4600 leaves memory unchanged.
- Fill 0x0000-0x000F, then pulse clear_req with 2 reads in flight. The 2 readdatavalids still arrive with pre-clear data, waitrequest stays high for 17920 cycles, and all words then read 0.

Source files
------------

// File: rtl/onchip_mem_pkg.sv
// onchip_mem_pkg: shared types and byte-merge helper for the dual-port on-chip memory.
package onchip_mem_pkg;
    localparam int MEM_DATA_W = 32;
    localparam int BE_W = MEM_DATA_W / 8;

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    function automatic logic [7:0] merge_byte(input logic hi_en, input logic [7:0] hi,
                                              input logic lo_en, input logic [7:0] lo,
                                              input logic [7:0] base);
        return hi_en ? hi : lo_en ? lo : base;
    endfunction
endpackage

// File: rtl/dpram_core.sv
// dpram_core: inferred true-dual-port RAM, per-port byte enables, one registered read per port.
module dpram_core
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int NB     = BE_W,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 17920
) (
    input  logic              clk,
    input  logic              i_a_we,
    input  logic              i_a_re,
    input  logic [NB-1:0]     i_a_be,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wd,
    output logic [DATA_W-1:0] o_a_q,
    input  logic              i_b_we,
    input  logic              i_b_re,
    input  logic [NB-1:0]     i_b_be,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wd,
    output logic [DATA_W-1:0] o_b_q
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (i_a_we && i_a_be[k]) r_mem[i_a_addr][k*8 +: 8] <= i_a_wd[k*8 +: 8];
            if (i_b_we && i_b_be[k]) r_mem[i_b_addr][k*8 +: 8] <= i_b_wd[k*8 +: 8];
        end
        if (i_a_re) o_a_q <= r_mem[i_a_addr];
        if (i_b_re) o_b_q <= r_mem[i_b_addr];
    end
endmodule

// File: rtl/onchip_mem_dp_ctrl.sv
// onchip_mem_dp_ctrl: dual-port Avalon-MM memory with zero-fill engine, collision policy and OOB flag.
module onchip_mem_dp_ctrl
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W         = MEM_DATA_W,
    parameter int ADDR_W         = 15,
    parameter int DEPTH          = 17920,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_byteenable,
    input  logic                a_chipselect,
    input  logic                a_read,
    input  logic                a_write,
    input  logic [DATA_W-1:0]   a_writedata,
    output logic [DATA_W-1:0]   a_readdata,
    output logic                a_readdatavalid,
    output logic                a_waitrequest,
    input  logic [ADDR_W-1:0]   b_address,
    input  logic [DATA_W/8-1:0] b_byteenable,
    input  logic                b_chipselect,
    input  logic                b_read,
    input  logic                b_write,
    input  logic [DATA_W-1:0]   b_writedata,
    output logic [DATA_W-1:0]   b_readdata,
    output logic                b_readdatavalid,
    output logic                b_waitrequest,
    input  logic                clear_req,
    output logic                init_busy,
    output logic                oob_err
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_oob;
    logic              w_clr, w_same, w_ww;
    logic [1:0]        w_cs, w_rd_in, w_wr_in, w_acc, w_oob, w_wr, w_rd, w_core_we, w_vld;
    logic [1:0][ADDR_W-1:0] w_addr, w_core_addr;
    logic [1:0][NB-1:0]     w_be, w_core_be;
    logic [1:0][DATA_W-1:0] w_wd, w_core_wd, w_q, w_d1, w_out;
    logic [DATA_W-1:0]      w_mwd;

    assign w_clr   = r_state == CLEAR;
    assign w_cs    = {b_chipselect, a_chipselect};
    assign w_rd_in = {b_read, a_read};
    assign w_wr_in = {b_write, a_write};
    assign w_addr  = {b_address, a_address};
    assign w_be    = {b_byteenable, a_byteenable};
    assign w_wd    = {b_writedata, a_writedata};
    assign w_same  = a_address == b_address;
    assign w_ww    = &w_wr & w_same;

    // Same-address double write is folded into one port-A write so A's lanes win.
    for (genvar j = 0; j < NB; j++) begin : g_merge
        assign w_mwd[j*8 +: 8] = merge_byte(a_byteenable[j], a_writedata[j*8 +: 8],
                                            b_byteenable[j], b_writedata[j*8 +: 8], 8'h00);
    end

    assign w_core_we      = {w_wr[1] & ~w_ww, w_clr | w_wr[0]};
    assign w_core_addr[0] = w_clr ? r_clr_cnt : w_oob[0] ? '0 : w_addr[0];
    assign w_core_addr[1] = w_oob[1] ? '0 : w_addr[1];
    assign w_core_be[0]   = w_clr ? '1 : w_ww ? (a_byteenable | b_byteenable) : a_byteenable;
    assign w_core_be[1]   = b_byteenable;
    assign w_core_wd[0]   = w_clr ? '0 : w_ww ? w_mwd : a_writedata;
    assign w_core_wd[1]   = b_writedata;

    dpram_core #(.DATA_W(DATA_W), .NB(NB), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_core (
        .clk     (clk),
        .i_a_we  (w_core_we[0]),
        .i_a_re  (w_rd[0]),
        .i_a_be  (w_core_be[0]),
        .i_a_addr(w_core_addr[0]),
        .i_a_wd  (w_core_wd[0]),
        .o_a_q   (w_q[0]),
        .i_b_we  (w_core_we[1]),
        .i_b_re  (w_rd[1]),
        .i_b_be  (w_core_be[1]),
        .i_b_addr(w_core_addr[1]),
        .i_b_wd  (w_core_wd[1]),
        .o_b_q   (w_q[1])
    );

    for (genvar i = 0; i < 2; i++) begin : g_port
        localparam int OTH = 1 - i;
        logic              r_v1, r_z1;
        logic [NB-1:0]     r_fm1;
        logic [DATA_W-1:0] r_fd1;
        assign w_acc[i] = w_cs[i] & (w_rd_in[i] | w_wr_in[i]) & ~w_clr;
        assign w_oob[i] = {1'b0, w_addr[i]} >= DEPTH_L;
        assign w_wr[i]  = w_acc[i] & w_wr_in[i] & ~w_oob[i];
        assign w_rd[i]  = w_acc[i] & w_rd_in[i] & ~w_wr_in[i];
        // The array reads old data; lanes written by the other port this cycle are patched in.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_v1  <= 1'b0;
                r_z1  <= 1'b1;
                r_fm1 <= '0;
                r_fd1 <= '0;
            end else begin
                r_v1 <= w_rd[i];
                if (w_rd[i]) begin
                    r_z1  <= w_oob[i];
                    r_fm1 <= (w_wr[OTH] && w_same) ? w_be[OTH] : '0;
                    r_fd1 <= w_wd[OTH];
                end
            end
        end
        for (genvar j = 0; j < NB; j++) begin : g_byte
            assign w_d1[i][j*8 +: 8] = r_z1 ? 8'h00 :
                merge_byte(r_fm1[j], r_fd1[j*8 +: 8], 1'b0, 8'h00, w_q[i][j*8 +: 8]);
        end
        if (READ_LATENCY == 2) begin : g_lat2
            logic              r_v2;
            logic [DATA_W-1:0] r_d2;
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) r_d2 <= w_d1[i];
                end
            end
            assign w_out[i] = r_d2;
            assign w_vld[i] = r_v2;
        end else begin : g_lat1
            assign w_out[i] = w_d1[i];
            assign w_vld[i] = r_v1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            r_clr_cnt <= '0;
            r_oob     <= 1'b0;
        end else begin
            r_oob <= r_oob | (|(w_acc & w_oob));
            if (w_clr) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
                if (r_clr_cnt == LAST) r_state <= READY;
            end else if (clear_req) begin
                r_state   <= CLEAR;
                r_clr_cnt <= '0;
            end
        end
    end

    assign a_readdata      = w_out[0];
    assign b_readdata      = w_out[1];
    assign a_readdatavalid = w_vld[0];
    assign b_readdatavalid = w_vld[1];
    assign a_waitrequest   = w_clr;
    assign b_waitrequest   = w_clr;
    assign init_busy       = w_clr;
    assign oob_err         = r_oob;
endmodule
